tisaradc_capture: RTL

//  Snapshot capture buffer downstream of the 8-way TI-SAR ADC. Registers the eight 9-bit sub-ADC words

---
 rtl/tisaradc_capture.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/tisaradc_capture.sv
// tisaradc_capture
//   Snapshot capture buffer for the 8-way TI-SAR ADC. Registers one frame
//   (all lanes) per deserialized clock, optionally converting offset binary
//   to two's complement. After ARM, an immediate or lane-0 level-crossing
//   trigger starts a capture of DEPTH consecutive frames into a buffer. The
//   buffer is read back through a one-cycle-latency random-access port.
// Ports
//   CLKOUT_DES  deserialized ADC clock (rising edge)
//   RSTN        asynchronous active-low reset
//   ADCIN       lane k at [k*ADC_BITS +: ADC_BITS], lane 0 first in time
//   TWOS        1: invert each lane MSB before storing
//   ARM/ABORT   start request / return to IDLE (ABORT wins)
//   TRIG_MODE   0: immediate, 1: rising crossing of TRIG_LEVEL on raw lane 0
//   TRIG_LEVEL  crossing threshold (unsigned, raw code)
//   RD_EN/RD_ADDR -> RD_DATA/RD_VALID one cycle later
//   STATE       0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE
//   FRAMES      frames written in the current/last capture
module tisaradc_capture #(
  parameter int ADC_WAYS = 8,
  parameter int ADC_BITS = 9,
  parameter int DEPTH    = 64,
  parameter int ADDR_W   = 6
) (
  input  logic                         CLKOUT_DES,
  input  logic                         RSTN,
  input  logic [ADC_WAYS*ADC_BITS-1:0] ADCIN,
  input  logic                         TWOS,
  input  logic                         ARM,
  input  logic                         ABORT,
  input  logic                         TRIG_MODE,
  input  logic [ADC_BITS-1:0]          TRIG_LEVEL,
  input  logic                         RD_EN,
  input  logic [ADDR_W-1:0]            RD_ADDR,
  output logic [ADC_WAYS*ADC_BITS-1:0] RD_DATA,
  output logic                         RD_VALID,
  output logic [1:0]                   STATE,
  output logic [ADDR_W:0]              FRAMES
);

  localparam int W = ADC_WAYS * ADC_BITS;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W:0]     r_frames, w_frames_nxt;
  logic [W-1:0]        r_in_q;
  logic [ADC_BITS-1:0] r_raw0_q;
  logic [ADC_BITS-1:0] r_prev0;
  logic                r_prev_valid;
  logic [W-1:0]        r_rd_data;
  logic                r_rd_valid;
  logic [W-1:0]        w_msb_mask;
  logic                w_trig;
  logic                w_we;
  logic [ADDR_W-1:0]   w_waddr;
  logic [W-1:0]        r_mem [DEPTH];

  always_comb begin
    w_msb_mask = '0;
    for (int unsigned k = 0; k < ADC_WAYS; k++) begin
      w_msb_mask[k*ADC_BITS + ADC_BITS - 1] = 1'b1;
    end
  end

  // raw0/prev0 track the unconverted lane-0 code so the threshold compare
  // is independent of TWOS.
  always_ff @(posedge CLKOUT_DES or negedge RSTN) begin
    if (!RSTN) begin
      r_in_q       <= '0;
      r_raw0_q     <= '0;
      r_prev0      <= '0;
      r_prev_valid <= 1'b0;
    end else begin
      r_in_q       <= TWOS ? (ADCIN ^ w_msb_mask) : ADCIN;
      r_raw0_q     <= ADCIN[ADC_BITS-1:0];
      r_prev0      <= r_raw0_q;
      r_prev_valid <= 1'b1;
    end
  end

  assign w_trig = !TRIG_MODE ||
                  (r_prev_valid && (r_prev0 < TRIG_LEVEL) && (r_raw0_q >= TRIG_LEVEL));

  always_ff @(posedge CLKOUT_DES or negedge RSTN) begin
    if (!RSTN) begin
      r_state  <= S_IDLE;
      r_frames <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_frames <= w_frames_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_frames_nxt = r_frames;
    w_we         = 1'b0;
    w_waddr      = r_frames[ADDR_W-1:0];
    if (ABORT) begin
      w_state_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (ARM) begin
            w_state_nxt  = S_ARMED;
            w_frames_nxt = '0;
          end
        end
        S_ARMED: begin
          if (w_trig) begin
            w_we         = 1'b1;
            w_waddr      = '0;
            w_frames_nxt = {{ADDR_W{1'b0}}, 1'b1};
            w_state_nxt  = S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          w_we         = 1'b1;
          w_frames_nxt = r_frames + 1'b1;
          // Writing the last address (all ones) completes the capture.
          if (r_frames[ADDR_W-1:0] == '1) begin
            w_state_nxt = S_DONE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLKOUT_DES) begin
    if (w_we) begin
      r_mem[w_waddr] <= r_in_q;
    end
  end

  // Non-blocking write above makes a same-cycle read of the written
  // address return the old contents.
  always_ff @(posedge CLKOUT_DES or negedge RSTN) begin
    if (!RSTN) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= RD_EN;
      if (RD_EN) begin
        r_rd_data <= r_mem[RD_ADDR];
      end
    end
  end

  assign RD_DATA  = r_rd_data;
  assign RD_VALID = r_rd_valid;
  assign STATE    = r_state;
  assign FRAMES   = r_frames;

endmodule
